// File: rtl/n1_core_v2.sv
// n1_core_v2: multi-cycle FETCH/EXEC CPU with a host load/readback port,
// a return-address stack, signed-compare branches and fault reporting.
module n1_core_v2 #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 7,
  parameter int STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int SI_W  = $clog2(STACK_DEPTH);
  localparam int SP_W  = SI_W + 1;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MOVI  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MUL   = 4'h5;
  localparam logic [3:0] OP_DIV   = 4'h6;
  localparam logic [3:0] OP_OUT   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'h8;
  localparam logic [3:0] OP_CMP   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JNE   = 4'hB;
  localparam logic [3:0] OP_JLE   = 4'hC;
  localparam logic [3:0] OP_CALL  = 4'hD;
  localparam logic [3:0] OP_RET   = 4'hE;
  localparam logic [3:0] OP_LOAD  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [SP_W-1:0]   sp_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] rf_q [8];
  logic              n_q, z_q, c_q, v_q;
  logic [1:0]        fault_code_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] host_rdata_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [3:0]        op;
  logic [2:0]        rd_idx, rs1_idx, rs2_idx;
  logic [7:0]        imm;
  logic [ADDR_W-1:0] maddr;

  assign op      = ir_q[15:12];
  assign rd_idx  = ir_q[11:9];
  assign rs1_idx = ir_q[8:6];
  assign rs2_idx = ir_q[5:3];
  assign imm     = ir_q[7:0];
  assign maddr   = imm[ADDR_W-1:0];

  logic [DATA_W-1:0] rd_val, rs1_val, rs2_val, mem_rd_val;

  assign rd_val     = rf_q[rd_idx];
  assign rs1_val    = rf_q[rs1_idx];
  assign rs2_val    = rf_q[rs2_idx];
  assign mem_rd_val = mem_q[maddr];

  // One extra bit on add/sub exposes carry-out / borrow for the C flag.
  logic [DATA_W:0]   add_d, sub_d, cmp_d;
  logic [DATA_W-1:0] mul_d, div_d;
  logic              add_v, sub_v, cmp_v, div_zero;

  assign add_d    = {1'b0, rs1_val} + {1'b0, rs2_val};
  assign sub_d    = {1'b0, rs1_val} - {1'b0, rs2_val};
  assign cmp_d    = {1'b0, rd_val} - {1'b0, rs1_val};
  assign add_v    = (rs1_val[DATA_W-1] == rs2_val[DATA_W-1]) &&
                    (add_d[DATA_W-1] != rs1_val[DATA_W-1]);
  assign sub_v    = (rs1_val[DATA_W-1] != rs2_val[DATA_W-1]) &&
                    (sub_d[DATA_W-1] != rs1_val[DATA_W-1]);
  assign cmp_v    = (rd_val[DATA_W-1] != rs1_val[DATA_W-1]) &&
                    (cmp_d[DATA_W-1] != rd_val[DATA_W-1]);
  assign div_zero = (rs2_val == '0);
  assign mul_d    = rs1_val * rs2_val;
  assign div_d    = div_zero ? '0 : rs1_val / rs2_val;

  logic [ADDR_W-1:0] pc_inc;
  logic [SP_W-1:0]   sp_inc, sp_dec;
  logic [ADDR_W-1:0] stack_top;
  logic              stack_full, stack_empty;
  logic              idle_like, in_exec;

  assign pc_inc      = pc_q + ADDR_W'(1);
  assign sp_inc      = sp_q + SP_W'(1);
  assign sp_dec      = sp_q - SP_W'(1);
  assign stack_top   = stack_q[SI_W'(sp_dec)];
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign idle_like   = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_FAULT);
  assign in_exec     = (state_q == S_EXEC);

  logic jump_taken;

  always_comb begin
    jump_taken = 1'b0;
    case (op)
      OP_JMP:  jump_taken = 1'b1;
      OP_JNE:  jump_taken = !z_q;
      OP_JLE:  jump_taken = z_q || (n_q != v_q);
      default: jump_taken = 1'b0;
    endcase
  end

  // Single RAM write port: host owns it while stopped, STORE owns it in EXEC.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = host_addr;
    mem_wdata = host_wdata;
    if (rst_n) begin
      if (idle_like) begin
        mem_we = host_we;
      end else if (in_exec && op == OP_STORE) begin
        mem_we    = 1'b1;
        mem_waddr = maddr;
        mem_wdata = rd_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  logic stack_we;
  assign stack_we = rst_n && in_exec && (op == OP_CALL) && !stack_full;

  always_ff @(posedge clk) begin
    if (stack_we) stack_q[SI_W'(sp_q)] <= pc_inc;
  end

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = '0;
    if (in_exec) begin
      case (op)
        OP_MOVI: begin rf_we = 1'b1;      rf_wdata = DATA_W'(imm);        end
        OP_ADD:  begin rf_we = 1'b1;      rf_wdata = add_d[DATA_W-1:0];   end
        OP_SUB:  begin rf_we = 1'b1;      rf_wdata = sub_d[DATA_W-1:0];   end
        OP_MUL:  begin rf_we = 1'b1;      rf_wdata = mul_d;               end
        OP_DIV:  begin rf_we = !div_zero; rf_wdata = div_d;               end
        OP_LOAD: begin rf_we = 1'b1;      rf_wdata = mem_rd_val;          end
        default: begin rf_we = 1'b0;      rf_wdata = '0;                  end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      sp_q         <= '0;
      ir_q         <= '0;
      {n_q, z_q, c_q, v_q} <= 4'b0000;
      fault_code_q <= 2'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      host_rdata_q <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      host_rdata_q <= mem_q[host_addr];
      out_valid_q  <= 1'b0;
      if (rf_we) rf_q[rd_idx] <= rf_wdata;
      case (state_q)
        S_IDLE, S_HALT, S_FAULT: begin
          if (run) begin
            pc_q         <= '0;
            sp_q         <= '0;
            {n_q, z_q, c_q, v_q} <= 4'b0000;
            fault_code_q <= 2'd0;
            state_q      <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir_q    <= mem_q[pc_q][15:0];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          pc_q    <= jump_taken ? maddr : pc_inc;
          case (op)
            OP_ADD: begin
              c_q <= add_d[DATA_W];
              v_q <= add_v;
              n_q <= add_d[DATA_W-1];
              z_q <= (add_d[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              c_q <= !sub_d[DATA_W];
              v_q <= sub_v;
              n_q <= sub_d[DATA_W-1];
              z_q <= (sub_d[DATA_W-1:0] == '0);
            end
            OP_CMP: begin
              c_q <= !cmp_d[DATA_W];
              v_q <= cmp_v;
              n_q <= cmp_d[DATA_W-1];
              z_q <= (cmp_d[DATA_W-1:0] == '0);
            end
            OP_MUL: begin
              n_q <= mul_d[DATA_W-1];
              z_q <= (mul_d == '0);
            end
            OP_DIV: begin
              if (div_zero) begin
                state_q      <= S_FAULT;
                fault_code_q <= 2'd1;
                pc_q         <= pc_q;
              end else begin
                n_q <= div_d[DATA_W-1];
                z_q <= (div_d == '0);
              end
            end
            OP_OUT: begin
              out_data_q  <= mem_rd_val;
              out_valid_q <= 1'b1;
            end
            OP_HALT: begin
              state_q <= S_HALT;
              pc_q    <= pc_q;
            end
            OP_CALL: begin
              if (stack_full) begin
                state_q      <= S_FAULT;
                fault_code_q <= 2'd2;
                pc_q         <= pc_q;
              end else begin
                sp_q <= sp_inc;
                pc_q <= maddr;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                state_q      <= S_FAULT;
                fault_code_q <= 2'd3;
                pc_q         <= pc_q;
              end else begin
                sp_q <= sp_dec;
                pc_q <= stack_top;
              end
            end
            default: begin
            end
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted     = (state_q == S_HALT);
  assign fault      = (state_q == S_FAULT);
  assign fault_code = fault_code_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: doc/n1_core_v2.md
Name: n1_core_v2

Overview:
- Parametrised successor to the n1 16-bit teaching CPU.
- Multi-cycle FETCH/EXEC core: configurable data width, RAM depth and call-stack depth.
- Adds host load/readback port, explicit run/halt/fault FSM, signed compare branching, LOAD opcode and fault reporting.
- Sits under the tt_um top: the top maps pins onto the host port and the output stream.

Parameters:
- DATA_W, 16: register/RAM word width; must be >=16 (instruction occupies bits [15:0]).
- ADDR_W, 7: RAM address bits; depth = 2^ADDR_W; must be <=8.
- STACK_DEPTH, 16: return-address stack entries; power of two, >=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- run  in  1  start pulse; honoured only in IDLE/HALT/FAULT
- host_we  in  1  RAM write strobe; honoured only when not running
- host_addr  in  ADDR_W  host RAM address
- host_wdata  in  DATA_W  host write data
- host_rdata  out  DATA_W  registered RAM[host_addr], 1-cycle latency, always active
- busy  out  1  high in FETCH/EXEC
- halted  out  1  high in HALT
- fault  out  1  high in FAULT
- fault_code  out  2  1=div-by-zero, 2=stack overflow, 3=stack underflow, 0=none
- out_valid  out  1  one-cycle pulse per OUT instruction
- out_data  out  DATA_W  value of last OUT; held until next OUT

Behaviour:
- Reset: state IDLE; pc, sp, ir, r0..r7, N/Z/C/V, host_rdata, out_data, fault_code = 0; all flag outputs 0. RAM contents not cleared.
- RAM: DATA_W x 2^ADDR_W. Synchronous write, combinational read internally.
- FSM states: IDLE, FETCH, EXEC, HALT, FAULT.
- IDLE/HALT/FAULT + run=1: pc, sp, flags, fault_code cleared; registers retained; next state FETCH.
- FETCH: ir <= RAM[pc]; next state EXEC.
- EXEC: execute ir; next state FETCH unless HALT/fault. Each instruction takes exactly 2 cycles.
- run while busy: ignored. host_we while busy: ignored, RAM unchanged.
- host_we and run in same cycle: write lands on that edge; first FETCH sees it.
- Encoding: op=ir[15:12], rd=ir[11:9], rs1=ir[8:6], rs2=ir[5:3], imm=ir[7:0]. Memory address = imm[ADDR_W-1:0].
- Results are DATA_W wide; imm zero-extended.
- Default next pc = pc+1, modulo 2^ADDR_W (wrap-around).
- Opcodes:
  - 0 NOP.
  - 1 MOVI: rd<=imm.
  - 2 STORE: RAM[imm]<=rd.
  - 3 ADD: rd<=rs1+rs2. C=carry out; V=signed overflow; N, Z from result.
  - 4 SUB: rd<=rs1-rs2. C=no-borrow (1 when rs1>=rs2 unsigned); V, N, Z from result.
  - 5 MUL: rd<=low DATA_W bits of product; N, Z updated; C, V unchanged.
  - 6 DIV: unsigned quotient; N, Z updated. rs2==0 -> FAULT, code 1, rd unchanged.
  - 7 OUT: out_data<=RAM[imm]; out_valid=1 for the cycle after EXEC.
  - 8 HALT -> HALT state; pc holds address of HALT.
  - 9 CMP: flags as SUB of rd-rs1; no register write.
  - A JMP: pc<=imm.
  - B JNE: jump if Z==0.
  - C JLE: jump if Z==1 or N!=V (signed less-or-equal).
  - D CALL: stack[sp]<=pc+1, sp++, pc<=imm. sp==STACK_DEPTH -> FAULT, code 2.
  - E RET: sp--, pc<=stack[sp-1]. sp==0 -> FAULT, code 3.
  - F LOAD: rd<=RAM[imm].
- Flags are updated only by ADD/SUB/CMP/MUL/DIV.
- On FAULT, pc holds the faulting instruction's address and no architectural write occurs for that instruction.
- Reset mid-run: returns to IDLE next edge; pending out_valid suppressed; RAM retained.

Test Plan:
- Host writes 0x1005@0, 0x8000@1; read addr 0 -> host_rdata=0x1005 one cycle later; run -> halted after 4 cycles, r0=5.
- MOVI r1=200, MOVI r2=100, ADD r3=r1+r2, STORE r3->0x40, OUT 0x40, HALT -> one out_valid pulse, out_data=300 (0x012C), C=0.
- MOVI r1=3, MOVI r2=5, CMP r1,r2, JLE 6 -> jump taken (N=1, V=0); with r1=5, r2=3 -> not taken, pc advances.
- Loop: r0=0, r1=1, r2=4; ADD r0+=r1; CMP r0,r2; JNE back -> exits with r0=4, Z=1; total cycles = 2 x executed instructions.
- CALL to subroutine doing MOVI r4=7; RET; HALT -> r4=7, sp=0. Nested CALL beyond STACK_DEPTH -> fault=1, fault_code=2. RET at sp=0 -> fault_code=3.
- DIV by r5=0 -> fault_code=1, rd unchanged. host_we during busy -> RAM unchanged. rst_n low mid-loop -> IDLE, busy=0, RAM readback intact.
